// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
// ID/EX pipeline register for the five-stage WISC-S24 pipeline.
//
// Captures the decoded operands, immediate, register specifiers and every
// EX/MEM/WB control bit from decode, and presents them to execute one cycle
// later. Supports hold (stall) and bubble insertion (flush). While held, the
// register snoops the writeback port so a stalled instruction never leaves
// with a stale source operand.
//
// Ports
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   stall, flush          : hold contents / replace contents with a bubble
//                           (flush wins over stall)
//   valid_in              : decode slot holds a real instruction
//   pc2_in                : PC+2 of the instruction
//   rs_data_in/rt_data_in : register-file read data
//   imm_in                : extended immediate
//   rs/rt/rd_id_in        : register specifiers
//   EX ctl  : ALUsrc_in, ALUop_in, ByteSel_in, set_N_in, set_V_in, set_Z_in
//   MEM ctl : MemRead_in, MemWrite_in
//   WB ctl  : RegWrite_in, MemtoReg_in, PCS_in, halt_in
//   wb_en, wb_id, wb_data : writeback port, snooped while stalled
//   *_out                 : registered copies of every *_in
//   valid_out             : EX slot holds a real instruction
//   halted                : sticky, set once a valid halt enters EX
// -----------------------------------------------------------------------------
module id_ex_reg #(
   parameter int DW = 16,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          flush,
   input  logic          valid_in,
   input  logic [DW-1:0] pc2_in,
   input  logic [DW-1:0] rs_data_in,
   input  logic [DW-1:0] rt_data_in,
   input  logic [DW-1:0] imm_in,
   input  logic [RW-1:0] rs_id_in,
   input  logic [RW-1:0] rt_id_in,
   input  logic [RW-1:0] rd_id_in,
   input  logic          ALUsrc_in,
   input  logic [2:0]    ALUop_in,
   input  logic          ByteSel_in,
   input  logic          set_N_in,
   input  logic          set_V_in,
   input  logic          set_Z_in,
   input  logic          MemRead_in,
   input  logic          MemWrite_in,
   input  logic          RegWrite_in,
   input  logic          MemtoReg_in,
   input  logic          PCS_in,
   input  logic          halt_in,
   input  logic          wb_en,
   input  logic [RW-1:0] wb_id,
   input  logic [DW-1:0] wb_data,
   output logic          valid_out,
   output logic [DW-1:0] pc2_out,
   output logic [DW-1:0] rs_data_out,
   output logic [DW-1:0] rt_data_out,
   output logic [DW-1:0] imm_out,
   output logic [RW-1:0] rs_id_out,
   output logic [RW-1:0] rt_id_out,
   output logic [RW-1:0] rd_id_out,
   output logic          ALUsrc_out,
   output logic [2:0]    ALUop_out,
   output logic          ByteSel_out,
   output logic          set_N_out,
   output logic          set_V_out,
   output logic          set_Z_out,
   output logic          MemRead_out,
   output logic          MemWrite_out,
   output logic          RegWrite_out,
   output logic          MemtoReg_out,
   output logic          PCS_out,
   output logic          halt_out,
   output logic          halted
);

   // All control bits travel together so that bubbles and non-valid slots
   // can clear them with a single assignment.
   typedef struct packed {
      logic       alusrc;
      logic [2:0] aluop;
      logic       bytesel;
      logic       set_n;
      logic       set_v;
      logic       set_z;
      logic       memread;
      logic       memwrite;
      logic       regwrite;
      logic       memtoreg;
      logic       pcs;
      logic       halt;
   } ctl_t;

   ctl_t          w_ctl_in;
   logic          w_load;
   logic          w_wb_live;
   logic          w_snoop_rs;
   logic          w_snoop_rt;

   logic          r_valid;
   logic [DW-1:0] r_pc2;
   logic [DW-1:0] r_rs_data;
   logic [DW-1:0] r_rt_data;
   logic [DW-1:0] r_imm;
   logic [RW-1:0] r_rs_id;
   logic [RW-1:0] r_rt_id;
   logic [RW-1:0] r_rd_id;
   ctl_t          r_ctl;
   logic          r_halted;

   assign w_ctl_in = '{
      alusrc:   ALUsrc_in,
      aluop:    ALUop_in,
      bytesel:  ByteSel_in,
      set_n:    set_N_in,
      set_v:    set_V_in,
      set_z:    set_Z_in,
      memread:  MemRead_in,
      memwrite: MemWrite_in,
      regwrite: RegWrite_in,
      memtoreg: MemtoReg_in,
      pcs:      PCS_in,
      halt:     halt_in
   };

   assign w_load = !flush && !stall;

   // A writeback to R0 is architecturally meaningless, and an empty slot has
   // no operands worth refreshing.
   assign w_wb_live  = wb_en && (wb_id != '0) && r_valid;
   assign w_snoop_rs = w_wb_live && (wb_id == r_rs_id);
   assign w_snoop_rt = w_wb_live && (wb_id == r_rt_id);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_pc2     <= '0;
         r_rs_data <= '0;
         r_rt_data <= '0;
         r_imm     <= '0;
         r_rs_id   <= '0;
         r_rt_id   <= '0;
         r_rd_id   <= '0;
         r_ctl     <= '0;
      end else if (flush) begin
         // Bubble: clears data and IDs too, even if a stall is also asserted.
         r_valid   <= 1'b0;
         r_pc2     <= '0;
         r_rs_data <= '0;
         r_rt_data <= '0;
         r_imm     <= '0;
         r_rs_id   <= '0;
         r_rt_id   <= '0;
         r_rd_id   <= '0;
         r_ctl     <= '0;
      end else if (stall) begin
         // Hold everything; only the source operands may be refreshed from
         // writeback, each independently.
         if (w_snoop_rs) begin
            r_rs_data <= wb_data;
         end
         if (w_snoop_rt) begin
            r_rt_data <= wb_data;
         end
      end else begin
         // No snoop on load: the register file already bypasses writes into
         // the decode read.
         r_valid   <= valid_in;
         r_pc2     <= pc2_in;
         r_rs_data <= rs_data_in;
         r_rt_data <= rt_data_in;
         r_imm     <= imm_in;
         r_rs_id   <= rs_id_in;
         r_rt_id   <= rt_id_in;
         r_rd_id   <= rd_id_in;
         // A non-valid slot must never write memory or registers.
         r_ctl     <= valid_in ? w_ctl_in : '0;
      end
   end

   // Sticky halt indicator; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_halted <= 1'b0;
      end else if (w_load && valid_in && halt_in) begin
         r_halted <= 1'b1;
      end
   end

   assign valid_out    = r_valid;
   assign pc2_out      = r_pc2;
   assign rs_data_out  = r_rs_data;
   assign rt_data_out  = r_rt_data;
   assign imm_out      = r_imm;
   assign rs_id_out    = r_rs_id;
   assign rt_id_out    = r_rt_id;
   assign rd_id_out    = r_rd_id;
   assign ALUsrc_out   = r_ctl.alusrc;
   assign ALUop_out    = r_ctl.aluop;
   assign ByteSel_out  = r_ctl.bytesel;
   assign set_N_out    = r_ctl.set_n;
   assign set_V_out    = r_ctl.set_v;
   assign set_Z_out    = r_ctl.set_z;
   assign MemRead_out  = r_ctl.memread;
   assign MemWrite_out = r_ctl.memwrite;
   assign RegWrite_out = r_ctl.regwrite;
   assign MemtoReg_out = r_ctl.memtoreg;
   assign PCS_out      = r_ctl.pcs;
   assign halt_out     = r_ctl.halt;
   assign halted       = r_halted;

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg
// Scoreboard bench for id_ex_reg. The driver computes the expected register
// contents from the behavioural rules at each cycle and queues them; a
// separate monitor pops one entry after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

   // Everything visible at the EX side of the register.
   typedef struct packed {
      logic        valid;
      logic [15:0] pc2;
      logic [15:0] rs_data;
      logic [15:0] rt_data;
      logic [15:0] imm;
      logic [3:0]  rs_id;
      logic [3:0]  rt_id;
      logic [3:0]  rd_id;
      logic        alusrc;
      logic        bytesel;
      logic        set_n;
      logic        set_v;
      logic        set_z;
      logic [2:0]  aluop;
      logic        memread;
      logic        memwrite;
      logic        regwrite;
      logic        memtoreg;
      logic        pcs;
      logic        halt;
      logic        halted;
   } slot_t;

   // Everything driven into the register.
   typedef struct packed {
      logic        stall;
      logic        flush;
      logic        valid;
      logic [15:0] pc2;
      logic [15:0] rs_data;
      logic [15:0] rt_data;
      logic [15:0] imm;
      logic [3:0]  rs_id;
      logic [3:0]  rt_id;
      logic [3:0]  rd_id;
      logic        alusrc;
      logic        bytesel;
      logic        set_n;
      logic        set_v;
      logic        set_z;
      logic [2:0]  aluop;
      logic        memread;
      logic        memwrite;
      logic        regwrite;
      logic        memtoreg;
      logic        pcs;
      logic        halt;
      logic        wb_en;
      logic [3:0]  wb_id;
      logic [15:0] wb_data;
   } in_t;

   logic  clk;
   logic  rst_n;
   in_t   din;
   slot_t got;
   slot_t mdl;
   slot_t exp_q[$];
   int    n_checks;
   int    n_fail;
   int    n_txn;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   id_ex_reg #(.DW(16), .RW(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (din.stall),
      .flush        (din.flush),
      .valid_in     (din.valid),
      .pc2_in       (din.pc2),
      .rs_data_in   (din.rs_data),
      .rt_data_in   (din.rt_data),
      .imm_in       (din.imm),
      .rs_id_in     (din.rs_id),
      .rt_id_in     (din.rt_id),
      .rd_id_in     (din.rd_id),
      .ALUsrc_in    (din.alusrc),
      .ALUop_in     (din.aluop),
      .ByteSel_in   (din.bytesel),
      .set_N_in     (din.set_n),
      .set_V_in     (din.set_v),
      .set_Z_in     (din.set_z),
      .MemRead_in   (din.memread),
      .MemWrite_in  (din.memwrite),
      .RegWrite_in  (din.regwrite),
      .MemtoReg_in  (din.memtoreg),
      .PCS_in       (din.pcs),
      .halt_in      (din.halt),
      .wb_en        (din.wb_en),
      .wb_id        (din.wb_id),
      .wb_data      (din.wb_data),
      .valid_out    (got.valid),
      .pc2_out      (got.pc2),
      .rs_data_out  (got.rs_data),
      .rt_data_out  (got.rt_data),
      .imm_out      (got.imm),
      .rs_id_out    (got.rs_id),
      .rt_id_out    (got.rt_id),
      .rd_id_out    (got.rd_id),
      .ALUsrc_out   (got.alusrc),
      .ALUop_out    (got.aluop),
      .ByteSel_out  (got.bytesel),
      .set_N_out    (got.set_n),
      .set_V_out    (got.set_v),
      .set_Z_out    (got.set_z),
      .MemRead_out  (got.memread),
      .MemWrite_out (got.memwrite),
      .RegWrite_out (got.regwrite),
      .MemtoReg_out (got.memtoreg),
      .PCS_out      (got.pcs),
      .halt_out     (got.halt),
      .halted       (got.halted)
   );

   // Behavioural rules for one clock edge.
   function automatic slot_t next_slot(slot_t c, in_t i);
      slot_t n;
      n = c;
      if (i.flush) begin
         n        = '0;
         n.halted = c.halted;
      end else if (i.stall) begin
         if (i.wb_en && i.wb_id != 4'd0 && c.valid) begin
            if (i.wb_id == c.rs_id) n.rs_data = i.wb_data;
            if (i.wb_id == c.rt_id) n.rt_data = i.wb_data;
         end
      end else begin
         n.valid    = i.valid;
         n.pc2      = i.pc2;
         n.rs_data  = i.rs_data;
         n.rt_data  = i.rt_data;
         n.imm      = i.imm;
         n.rs_id    = i.rs_id;
         n.rt_id    = i.rt_id;
         n.rd_id    = i.rd_id;
         n.alusrc   = i.valid & i.alusrc;
         n.bytesel  = i.valid & i.bytesel;
         n.set_n    = i.valid & i.set_n;
         n.set_v    = i.valid & i.set_v;
         n.set_z    = i.valid & i.set_z;
         n.aluop    = i.valid ? i.aluop : 3'd0;
         n.memread  = i.valid & i.memread;
         n.memwrite = i.valid & i.memwrite;
         n.regwrite = i.valid & i.regwrite;
         n.memtoreg = i.valid & i.memtoreg;
         n.pcs      = i.valid & i.pcs;
         n.halt     = i.valid & i.halt;
         n.halted   = c.halted | (i.valid & i.halt);
      end
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
      n_checks++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, g, e, $time);
      end
   endtask

   // Called at a falling edge with inputs already set: queue the expectation,
   // then let one rising edge pass and return at the next falling edge.
   task automatic step();
      mdl = next_slot(mdl, din);
      exp_q.push_back(mdl);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset(input string name);
      #2 rst_n = 1'b0;
      #1;
      chk(name, {31'd0, got != '0}, 32'd0);
      mdl = '0;
      exp_q.delete();
      #1 rst_n = 1'b1;
   endtask

   // Monitor: one comparison per rising edge that has an expectation queued.
   initial begin
      slot_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_txn++;
            n_checks++;
            if (got !== e) begin
               n_fail++;
               $display("FAIL slot txn=%0d got=%h exp=%h", n_txn, got, e);
            end else if (n_txn <= 24) begin
               $display("txn %0d v=%0b rs=%h rt=%h halted=%0b", n_txn, got.valid,
                        got.rs_data, got.rt_data, got.halted);
            end
         end
      end
   end

   initial begin
      logic [127:0] r;
      n_checks = 0;
      n_fail   = 0;
      n_txn    = 0;
      mdl      = '0;
      din      = '0;
      rst_n    = 1'b1;

      // Reset then load
      #2 rst_n = 1'b0;
      #1 chk("reset_all_zero", {31'd0, got != '0}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      din.valid = 1'b1; din.aluop = 3'b101; din.rs_data = 16'h1234; din.regwrite = 1'b1;
      step();
      chk("load_aluop", {29'd0, got.aluop}, 32'd5);
      chk("load_rs_data", {16'd0, got.rs_data}, 32'h1234);
      chk("load_regwrite", {31'd0, got.regwrite}, 32'd1);
      chk("load_valid", {31'd0, got.valid}, 32'd1);

      // Stall hold for three cycles with changing inputs
      din.stall = 1'b1;
      din.pc2 = 16'hFFFF; din.rs_data = 16'hFFFF; din.rt_data = 16'hFFFF; din.imm = 16'hFFFF;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_hold_rs", {16'd0, got.rs_data}, 32'h1234);
         chk("stall_hold_imm", {16'd0, got.imm}, 32'h0000);
      end
      din.stall = 1'b0;
      step();
      chk("stall_release", {16'd0, got.rs_data}, 32'hFFFF);

      // Flush beats stall
      din = '0; din.valid = 1'b1; din.memwrite = 1'b1; din.regwrite = 1'b1; din.rs_data = 16'h5555;
      step();
      chk("pre_flush_mw", {31'd0, got.memwrite}, 32'd1);
      din.stall = 1'b1; din.flush = 1'b1;
      step();
      chk("flush_valid", {31'd0, got.valid}, 32'd0);
      chk("flush_mw", {31'd0, got.memwrite}, 32'd0);
      chk("flush_rw", {31'd0, got.regwrite}, 32'd0);
      chk("flush_rs", {16'd0, got.rs_data}, 32'd0);

      // Snoop while stalled
      din = '0; din.valid = 1'b1; din.rs_id = 4'd3; din.rt_id = 4'd3;
      din.rs_data = 16'h0001; din.rt_data = 16'h0001;
      step();
      din.stall = 1'b1; din.wb_en = 1'b1; din.wb_id = 4'd3; din.wb_data = 16'hBEEF;
      step();
      chk("snoop_rs", {16'd0, got.rs_data}, 32'hBEEF);
      chk("snoop_rt", {16'd0, got.rt_data}, 32'hBEEF);
      din.wb_id = 4'd0; din.wb_data = 16'h1111;
      step();
      chk("snoop_r0_ignored", {16'd0, got.rs_data}, 32'hBEEF);
      din.stall = 1'b0; din.wb_id = 4'd3; din.rs_data = 16'h2222; din.rt_data = 16'h3333;
      step();
      chk("load_beats_wb_rs", {16'd0, got.rs_data}, 32'h2222);
      chk("load_beats_wb_rt", {16'd0, got.rt_data}, 32'h3333);

      // Bubble on invalid slot
      din = '0; din.regwrite = 1'b1; din.memwrite = 1'b1; din.imm = 16'h0042;
      step();
      chk("inv_rw", {31'd0, got.regwrite}, 32'd0);
      chk("inv_mw", {31'd0, got.memwrite}, 32'd0);
      chk("inv_imm", {16'd0, got.imm}, 32'h0042);
      chk("inv_valid", {31'd0, got.valid}, 32'd0);

      // Halt is sticky
      din = '0; din.valid = 1'b1; din.halt = 1'b1;
      step();
      chk("halt_set", {31'd0, got.halted}, 32'd1);
      din = '0; din.flush = 1'b1;
      step();
      din.flush = 1'b0; din.valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         din.pc2 = 16'(k * 2);
         step();
      end
      chk("halt_sticky", {31'd0, got.halted}, 32'd1);
      pulse_reset("halt_reset_zero");
      chk("halt_cleared", {31'd0, got.halted}, 32'd0);

      // Randomised traffic with occasional mid-cycle resets
      for (int c = 0; c < 3000; c++) begin
         r   = {$urandom, $urandom, $urandom, $urandom};
         din = r[$bits(in_t)-1:0];
         din.stall = ($urandom_range(0, 9) < 4);
         din.flush = ($urandom_range(0, 19) == 0);
         din.valid = ($urandom_range(0, 9) < 8);
         din.halt  = ($urandom_range(0, 99) == 0);
         din.rs_id = 4'($urandom_range(0, 3));
         din.rt_id = 4'($urandom_range(0, 3));
         din.wb_id = 4'($urandom_range(0, 3));
         step();
         if ($urandom_range(0, 399) == 0) pulse_reset("rand_reset_zero");
      end

      din = '0;
      @(posedge clk);
      #2 chk("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the five-stage WISC-S24 pipeline.
- Captures decoded operands, immediate, register IDs and all EX/MEM/WB control from decode, and presents them to execute.
- Supports hold (stall) and bubble insertion (flush).
- While held, snoops the writeback port so a stalled instruction never leaves with a stale operand.

Parameters:
- DW, 16, datapath width
- RW, 4, register-ID width (16 architectural registers, R0 reads as zero)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- stall  in  1  hold all contents this cycle
- flush  in  1  replace contents with bubble this cycle
- valid_in  in  1  decode slot holds a real instruction
- pc2_in  in  DW  PC+2 of the instruction
- rs_data_in, rt_data_in  in  DW each  register-file read data
- imm_in  in  DW  sign/zero-extended immediate
- rs_id_in, rt_id_in, rd_id_in  in  RW each  register specifiers
- ALUsrc_in, ByteSel_in, set_N_in, set_V_in, set_Z_in  in  1 each  EX control
- ALUop_in  in  3  ALU operation
- MemRead_in, MemWrite_in  in  1 each  MEM control
- RegWrite_in, MemtoReg_in, PCS_in, halt_in  in  1 each  WB control
- wb_en  in  1  writeback stage writing the register file
- wb_id  in  RW  writeback destination
- wb_data  in  DW  writeback value
- Every *_in above has a matching *_out of identical width
- valid_out  out  1  EX slot holds a real instruction
- halted  out  1  sticky: a valid halt has entered EX

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - all *_out = 0, valid_out = 0, halted = 0.
  - A reset mid-stall discards the held instruction.
- Per rising edge, priority flush > stall > load:
  - flush=1: valid_out and every control output (ALUsrc, ALUop, ByteSel, set_N/V/Z, MemRead, MemWrite, RegWrite, MemtoReg, PCS, halt) = 0. Data/ID outputs = 0. This holds even when stall=1 in the same cycle.
  - stall=1, flush=0: all outputs hold, except for the operand snoop below.
  - Otherwise (load): every *_out <= *_in, valid_out <= valid_in.
- Latency: one cycle from *_in to *_out on load.
- Operand snoop (stall=1, flush=0 only):
  - If wb_en=1, wb_id!=0, valid_out=1 and wb_id==rs_id_out, then rs_data_out <= wb_data.
  - The same rule applies independently to rt_id_out/rt_data_out. Both may update in the same cycle.
  - wb_id==0 never updates.
  - No snoop on load or flush: the register file provides write-before-read bypass for the decode read.
- valid_in=0 on load:
  - Control outputs are forced to 0, so a non-valid slot can never write memory or registers.
  - Data fields still load.
- halted:
  - Set on the edge that loads valid_in=1 with halt_in=1 (stall=0, flush=0).
  - Cleared only by reset. Unaffected by later flush or stall.
- No combinational path from any input to any output.

Test Plan:
- Reset then load: assert rst_n=0 mid-cycle, then release. Load valid_in=1, ALUop_in=3'b101, rs_data_in=16'h1234, RegWrite_in=1 -> all outputs 0 asynchronously during reset; the next edge gives ALUop_out=3'b101, rs_data_out=16'h1234, RegWrite_out=1, valid_out=1.
- Stall hold: load an instruction, then stall=1 for 3 cycles while the inputs change to 16'hFFFF -> outputs unchanged for all 3 cycles. Release the stall -> new values appear 1 cycle later.
- Flush beats stall: valid instruction with MemWrite_out=1, then stall=1 and flush=1 together -> valid_out=0, MemWrite_out=0, RegWrite_out=0, rs_data_out=0 after that edge.
- Snoop during stall: held rs_id_out=4'd3, rt_id_out=4'd3, rs_data_out=16'h0001. Drive stall=1, wb_en=1, wb_id=3, wb_data=16'hBEEF -> rs_data_out=rt_data_out=16'hBEEF. Repeat with wb_id=0 -> no change. Repeat with stall=0 -> the loaded *_in values win.
- Bubble on invalid: valid_in=0 with RegWrite_in=1, MemWrite_in=1, imm_in=16'h0042 -> RegWrite_out=0, MemWrite_out=0, imm_out=16'h0042, valid_out=0.
- Halt sticky: load valid_in=1, halt_in=1 -> halted=1. Flush and load 5 further instructions -> halted stays 1. Pulse rst_n low -> halted=0.
